// File: rtl/dcache_responder_pkg.sv
// Shared types for the data-cache responder: word type, address/frame views
// for the default 16-frame geometry, and the controller state encoding.
package dcache_responder_pkg;

  typedef logic [31:0] word_t;

  localparam int DC_SETS  = 16;
  localparam int DC_IDX_W = $clog2(DC_SETS);
  localparam int DC_TAG_W = 32 - 3 - DC_IDX_W;

  typedef struct packed {
    logic [DC_TAG_W-1:0] tag;
    logic [DC_IDX_W-1:0] idx;
    logic                blkoff;
    logic [1:0]          bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [DC_TAG_W-1:0] tag;
    word_t [1:0]         data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE
  } dstate_t;

endpackage

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache (2-word blocks) with an LL/SC link
// register and a halt-triggered flush of dirty frames.
//   IDLE  | serve hits, start miss handling or flush
//   WB*   | write back evicted dirty block, word 0/1
//   LD*   | fill requested block from memory, word 0/1
//   FLUSH | inspect frame[flush_cnt]; FWB* write it back if dirty
//   DONE  | flush complete, flushed held until reset
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int SETS = DC_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 29 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  logic [SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [SETS];
  word_t            data_q [SETS][2];
  word_t            fill_q;
  logic             link_valid_q;
  logic [29:0]      link_addr_q;
  logic [IDX_W-1:0] flush_cnt_q;
  dstate_t          state_q, state_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx, mem_idx;
  logic             req_blk, mem_blk, flushing, last;
  logic             req, is_write, is_ll, is_sc, link_match, tag_hit, xfer_done;
  logic             wr_hit, ll_hit, fill_word0, fill_commit, flush_clean, cnt_inc;
  logic             unused_byte;

  assign req_tag     = dmemaddr[31:3+IDX_W];
  assign req_idx     = dmemaddr[2+IDX_W:3];
  assign req_blk     = dmemaddr[2];
  assign unused_byte = ^dmemaddr[1:0];

  assign req        = dmemREN | dmemWEN;
  assign is_write   = dmemWEN;
  assign is_ll      = datomic & dmemREN & ~dmemWEN;
  assign is_sc      = datomic & dmemWEN;
  assign link_match = link_valid_q & (link_addr_q == dmemaddr[31:2]);
  assign tag_hit    = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign xfer_done  = ~dwait;

  // Memory traffic addresses the flush frame while flushing, else the request frame.
  assign flushing = (state_q == FLUSH) || (state_q == FWB0) || (state_q == FWB1);
  assign mem_idx  = flushing ? flush_cnt_q : req_idx;
  assign mem_blk  = (state_q == WB1) || (state_q == LD1) || (state_q == FWB1);
  assign last     = (flush_cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    dhit        = 1'b0;
    dmemload    = '0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    flushed     = 1'b0;
    wr_hit      = 1'b0;
    ll_hit      = 1'b0;
    fill_word0  = 1'b0;
    fill_commit = 1'b0;
    flush_clean = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_sc && !link_match) begin
            dhit = 1'b1;
          end else if (tag_hit) begin
            dhit     = 1'b1;
            wr_hit   = is_write;
            ll_hit   = is_ll;
            dmemload = is_sc ? 32'd1 : data_q[req_idx][req_blk];
          end else begin
            state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB0 : LD0;
          end
        end else if (halt) begin
          state_d = FLUSH;
        end
      end
      WB0, WB1, FWB0, FWB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[mem_idx], mem_idx, mem_blk, 2'b00};
        dstore = data_q[mem_idx][mem_blk];
        if (xfer_done) begin
          case (state_q)
            WB0:     state_d = WB1;
            WB1:     state_d = LD0;
            FWB0:    state_d = FWB1;
            default: begin
              flush_clean = 1'b1;
              if (last) begin
                state_d = DONE;
              end else begin
                cnt_inc = 1'b1;
                state_d = FLUSH;
              end
            end
          endcase
        end
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, mem_blk, 2'b00};
        if (xfer_done) begin
          if (state_q == LD0) begin
            fill_word0 = 1'b1;
            state_d    = LD1;
          end else begin
            fill_commit = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      FLUSH: begin
        if (valid_q[flush_cnt_q] && dirty_q[flush_cnt_q]) state_d = FWB0;
        else if (last) state_d = DONE;
        else cnt_inc = 1'b1;
      end
      DONE:    flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_inc) flush_cnt_q <= flush_cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else if (ll_hit) begin
      link_valid_q <= 1'b1;
      link_addr_q  <= dmemaddr[31:2];
    end else if (wr_hit && link_match) begin
      link_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_commit) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (wr_hit) dirty_q[req_idx] <= 1'b1;
      if (flush_clean) dirty_q[flush_cnt_q] <= 1'b0;
    end
  end

  // Word 0 of a fill is staged so the frame only changes once both words arrive.
  always_ff @(posedge CLK) begin
    if (fill_word0) fill_q <= dload;
    if (fill_commit) begin
      tag_q[req_idx]     <= req_tag;
      data_q[req_idx][0] <= fill_q;
      data_q[req_idx][1] <= dload;
    end
    if (wr_hit) data_q[req_idx][req_blk] <= dmemstore;
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios plus random traffic checked
// against an array-level cache/memory model and a latency-programmable memory.
module tb_dcache_responder;

  localparam int SETS = 16;
  localparam int MEMW = 4096;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0, halt = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic        dwait = 1'b1;
  logic [31:0] dload = '0;

  always #5 CLK = ~CLK;

  dcache_responder #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic [31:0] mem [MEMW];
  xfer_t       log_q[$];
  int          lat = 2;
  bit          rand_lat = 1'b0;
  int          wait_left = 2;
  int          proto_err = 0;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  function automatic int next_lat();
    return rand_lat ? int'($urandom_range(0, 3)) : lat;
  endfunction

  // Memory: decides dwait on the falling edge; a transfer completes on the next rising edge.
  always @(negedge CLK) begin
    if (dREN && dWEN) proto_err++;
    if (dREN || dWEN) begin
      if (wait_left > 0) begin
        dwait = 1'b1;
        wait_left--;
      end else begin
        dwait = 1'b0;
        if (dWEN) begin
          mem[daddr[13:2]] = dstore;
          log_q.push_back('{1'b1, daddr, dstore});
        end else begin
          dload = mem[daddr[13:2]];
          log_q.push_back('{1'b0, daddr, dload});
        end
        wait_left = next_lat();
      end
    end else begin
      dwait = 1'b1;
      wait_left = next_lat();
    end
  end

  // Reference: architectural memory image plus which block each frame holds.
  logic [31:0] arch [MEMW];
  bit          m_valid [SETS];
  bit          m_dirty [SETS];
  logic [24:0] m_tag [SETS];
  bit          m_link = 1'b0;
  logic [29:0] m_link_addr = '0;
  xfer_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_traffic(input string tag);
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    if (log_q.size() == exp_q.size())
      foreach (exp_q[i]) begin
        check({tag, "_dir"}, 64'(log_q[i].wr), 64'(exp_q[i].wr));
        check({tag, "_addr_data"}, {log_q[i].addr, log_q[i].data}, {exp_q[i].addr, exp_q[i].data});
      end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = '0;
    end
    m_link = 1'b0;
    for (int w = 0; w < MEMW; w++) arch[w] = mem[w];
  endtask

  function automatic logic [31:0] blk_addr(input logic [24:0] t, input logic [3:0] s, input bit b);
    return {t, s, b, 2'b00};
  endfunction

  task automatic model_fill(input logic [31:0] addr);
    logic [3:0]  s = addr[6:3];
    logic [24:0] t = addr[31:7];
    logic [31:0] a;
    if (!(m_valid[s] && m_tag[s] == t)) begin
      if (m_valid[s] && m_dirty[s])
        for (int b = 0; b < 2; b++) begin
          a = blk_addr(m_tag[s], s, b[0]);
          exp_q.push_back('{1'b1, a, arch[a[13:2]]});
        end
      for (int b = 0; b < 2; b++) begin
        a = blk_addr(t, s, b[0]);
        exp_q.push_back('{1'b0, a, arch[a[13:2]]});
      end
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic do_op(input bit ren, input bit wen, input bit atom,
                       input logic [31:0] addr, input logic [31:0] data);
    bit          ll = atom && ren && !wen;
    bit          sc = atom && wen;
    bit          sc_ok = sc && m_link && (m_link_addr == addr[31:2]);
    bit          chk_load = 1'b0, got = 1'b0;
    logic [31:0] exp_load = '0, got_load = '0;
    int          cyc = 0, exp_cyc;
    exp_q.delete();
    if (sc && !sc_ok) begin
      chk_load = 1'b1;
    end else begin
      model_fill(addr);
      if (wen) begin
        arch[addr[13:2]] = data;
        m_dirty[addr[6:3]] = 1'b1;
        if (m_link && m_link_addr == addr[31:2]) m_link = 1'b0;
        if (sc) begin chk_load = 1'b1; exp_load = 32'd1; end
      end else begin
        chk_load = 1'b1;
        exp_load = arch[addr[13:2]];
        if (ll) begin m_link = 1'b1; m_link_addr = addr[31:2]; end
      end
    end
    log_q.delete();
    @(negedge CLK);
    dmemREN = ren; dmemWEN = wen; datomic = atom; dmemaddr = addr; dmemstore = data;
    for (cyc = 0; cyc < 400; cyc++) begin
      #1;
      if (dhit) begin got = 1'b1; got_load = dmemload; break; end
      @(negedge CLK);
    end
    check("dhit_seen", 64'(got), 64'd1);
    if (got) begin
      if (chk_load) check("dmemload", 64'(got_load), 64'(exp_load));
      check_traffic("traffic");
      if (!rand_lat) begin
        exp_cyc = (exp_q.size() > 0) ? exp_q.size() * (lat + 1) + 1 : 0;
        check("latency", 64'(cyc), 64'(exp_cyc));
      end
    end
  endtask

  task automatic bus_idle();
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask

  initial begin
    logic [31:0] a, ll_addr;
    int          r, cyc;
    bit          seen;

    for (int w = 0; w < MEMW; w++) mem[w] = $urandom;
    mem[32'h40 >> 2] = 32'hAAAA0001;
    mem[32'h44 >> 2] = 32'hAAAA0002;
    model_reset();

    #1;
    check("reset_flags", {60'd0, dhit, flushed, dREN, dWEN}, 64'd0);
    check("reset_daddr", 64'(daddr), 64'd0);
    check("reset_dstore", 64'(dstore), 64'd0);
    check("reset_dmemload", 64'(dmemload), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Clean miss, then rehit
    lat = 2; rand_lat = 1'b0;
    do_op(1, 0, 0, 32'h40, 0);
    do_op(1, 0, 0, 32'h40, 0);
    do_op(1, 0, 0, 32'h44, 0);
    // Write hit then conflicting read forces writeback
    do_op(0, 1, 0, 32'h40, 32'h12345678);
    do_op(1, 0, 0, 32'h440, 0);
    // LL/SC pair, then SC with no link
    do_op(1, 0, 1, 32'h80, 0);
    do_op(0, 1, 1, 32'h80, 32'd7);
    do_op(1, 0, 0, 32'h80, 0);
    do_op(0, 1, 1, 32'h80, 32'd8);
    do_op(1, 0, 0, 32'h80, 0);
    // Plain store to the linked word breaks the link
    do_op(1, 0, 1, 32'h80, 0);
    do_op(0, 1, 0, 32'h80, 32'd9);
    do_op(0, 1, 1, 32'h80, 32'd10);
    do_op(1, 0, 0, 32'h80, 0);
    // Both enables high behaves as a write
    do_op(1, 1, 0, 32'h88, 32'hCAFE0001);
    do_op(1, 0, 0, 32'h88, 0);

    rand_lat = 1'b1;
    ll_addr = 32'h0;
    for (int i = 0; i < 300; i++) begin
      a = {23'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'b00};
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2: do_op(1, 0, 0, a, 0);
        3, 4:    do_op(0, 1, 0, a, $urandom);
        5:       begin ll_addr = a; do_op(1, 0, 1, a, 0); end
        6:       do_op(0, 1, 1, ($urandom_range(0, 1) == 1) ? ll_addr : a, $urandom);
        default: do_op(1, 1, ($urandom_range(0, 3) == 0), a, $urandom);
      endcase
    end
    bus_idle();

    // Reset while filling the second word
    rand_lat = 1'b0; lat = 3;
    log_q.delete();
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = 32'h380;
    seen = 1'b0;
    for (cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge CLK); #1;
      foreach (log_q[i]) if (!log_q[i].wr) seen = 1'b1;
    end
    check("ld0_reached", 64'(seen), 64'd1);
    @(posedge CLK); #1;
    check("ld1_dren", 64'(dREN), 64'd1);
    #1 nRST = 1'b0;
    #1;
    check("mid_reset_flags", {60'd0, dhit, flushed, dREN, dWEN}, 64'd0);
    check("mid_reset_daddr", 64'(daddr), 64'd0);
    check("mid_reset_dmemload", 64'(dmemload), 64'd0);
    dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    do_op(1, 0, 0, 32'h380, 0);
    do_op(1, 0, 0, 32'h384, 0);

    // Flush: dirty frames at index 0 and 5 only
    lat = 1;
    do_op(0, 1, 0, 32'h380, $urandom);
    do_op(0, 1, 0, 32'h2C, $urandom);
    do_op(1, 0, 0, 32'h90, 0);
    bus_idle();
    exp_q.delete();
    for (int s = 0; s < SETS; s++)
      if (m_valid[s] && m_dirty[s])
        for (int b = 0; b < 2; b++) begin
          a = blk_addr(m_tag[s], 4'(s), b[0]);
          exp_q.push_back('{1'b1, a, arch[a[13:2]]});
        end
    log_q.delete();
    @(negedge CLK);
    halt = 1'b1;
    seen = 1'b0;
    for (cyc = 0; cyc < 500 && !seen; cyc++) begin
      @(negedge CLK); #1;
      seen = flushed;
    end
    check("flushed_seen", 64'(seen), 64'd1);
    check_traffic("flush");
    check("flush_mem_idx0", 64'(mem[32'h384 >> 2]), 64'(arch[32'h384 >> 2]));
    check("flush_mem_idx5", 64'(mem[32'h2C >> 2]), 64'(arch[32'h2C >> 2]));
    halt = 1'b0;
    dmemREN = 1'b1; dmemaddr = 32'h90;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      check("done_flushed", 64'(flushed), 64'd1);
      check("done_no_dhit", 64'(dhit), 64'd0);
    end
    check("done_no_traffic", 64'(log_q.size()), 64'(exp_q.size()));
    dmemREN = 1'b0;
    check("dren_dwen_exclusive", 64'(proto_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
